// File: rtl/rns_forward_converter.sv
// Binary-to-RNS forward converter, moduli {2^N-1, 2^N+1, 2^2N+1, 2^(2N+P)}.
// Folds one N-bit chunk per cycle; valid/ready handshake on input and output.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake; x_in is the 6N+P bit operand
//   out_valid/out_ready output handshake; r1..r4 are the residues
//   r1  X mod (2^N-1)   r2  X mod (2^N+1)
//   r3  X mod (2^2N+1)  r4  X mod 2^(2N+P)
module rns_forward_converter #(
  parameter int N = 4,
  parameter int P = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6*N+P-1:0] x_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     r1,
  output logic [N:0]       r2,
  output logic [2*N:0]     r3,
  output logic [2*N+P-1:0] r4
);

  localparam int W  = 7 * N;
  localparam int W2 = N + 3;
  localparam int W3 = 2 * N + 4;
  localparam int V2 = N + 5;
  localparam int V3 = 2 * N + 5;

  localparam logic [V2-1:0] M2 = V2'((1 << N) + 1);
  localparam logic [V3-1:0] M3 = V3'((1 << (2 * N)) + 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    FINAL,
    HOLD
  } state_t;

  state_t state, state_nxt;

  logic [W-1:0]         lat;
  logic [2:0]           cnt;
  logic [N-1:0]         acc1, acc1_nxt;
  logic signed [W2-1:0] acc2, acc2_nxt;
  logic signed [W3-1:0] acc3, acc3_nxt;

  logic [N-1:0]         c;
  logic [N:0]           sum1;
  logic signed [W2-1:0] c2;
  logic signed [W3-1:0] c3, c3s, term3;

  // Bias by 4*M to get a non-negative value below 8*M,
  // then strip 4M, 2M and M by conditional subtraction.
  function automatic logic [N:0] norm2(
    input logic signed [W2-1:0] a
  );
    logic [V2-1:0] v;
    v = V2'(a) + (M2 << 2);
    for (int k = 2; k >= 0; k--) begin
      if (v >= (M2 << k)) v = v - (M2 << k);
    end
    return (N+1)'(v);
  endfunction

  function automatic logic [2*N:0] norm3(
    input logic signed [W3-1:0] a
  );
    logic [V3-1:0] v;
    v = V3'(a) + (M3 << 2);
    for (int k = 2; k >= 0; k--) begin
      if (v >= (M3 << k)) v = v - (M3 << k);
    end
    return (2*N+1)'(v);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ACCUM;
      end
      ACCUM: if (cnt == 3'd6) state_nxt = FINAL;
      FINAL: state_nxt = HOLD;
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The latched operand shifts down so the current chunk
  // always sits in the low N bits.
  always_comb begin
    c    = lat[N-1:0];
    sum1 = {1'b0, acc1} + {1'b0, c};
    // end-around carry: 2^N == 1 mod 2^N-1
    acc1_nxt = sum1[N-1:0] + {{(N-1){1'b0}}, sum1[N]};
    c2 = $signed({3'b000, c});
    acc2_nxt = cnt[0] ? acc2 - c2 : acc2 + c2;
    c3  = $signed({{(N+4){1'b0}}, c});
    c3s = $signed({4'b0000, c, {N{1'b0}}});
    // 2^2N == -1: weights cycle +1, +2^N, -1, -2^N
    term3 = cnt[0] ? c3s : c3;
    acc3_nxt = cnt[1] ? acc3 - term3 : acc3 + term3;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat  <= '0;
      cnt  <= '0;
      acc1 <= '0;
      acc2 <= '0;
      acc3 <= '0;
      r1   <= '0;
      r2   <= '0;
      r3   <= '0;
      r4   <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          lat  <= W'(x_in);
          cnt  <= '0;
          acc1 <= '0;
          acc2 <= '0;
          acc3 <= '0;
          r4   <= x_in[2*N+P-1:0];
        end
        ACCUM: begin
          lat  <= lat >> N;
          cnt  <= cnt + 3'd1;
          acc1 <= acc1_nxt;
          acc2 <= acc2_nxt;
          acc3 <= acc3_nxt;
        end
        FINAL: begin
          r1 <= (acc1 == {N{1'b1}}) ? '0 : acc1;
          r2 <= norm2(acc2);
          r3 <= norm3(acc3);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rns_forward_converter.sv
// Directed and randomised bench for rns_forward_converter.
// Instance a: N=2,P=0; instance b: N=4,P=2.
module tb_rns_forward_converter;

  localparam int NA = 2;
  localparam int PA = 0;
  localparam int NB = 4;
  localparam int PB = 2;
  localparam longint MB = 64'd67107840;

  if (PA > NA - 2 || PB > NB - 2) begin : g_bad_param
    initial $fatal(1, "FAIL param_range: P exceeds N-2");
  end

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_in_valid = 1'b0;
  logic        a_in_ready;
  logic [11:0] a_x = '0;
  logic        a_out_valid;
  logic        a_out_ready = 1'b0;
  logic [1:0]  a_r1;
  logic [2:0]  a_r2;
  logic [4:0]  a_r3;
  logic [3:0]  a_r4;

  logic        b_in_valid = 1'b0;
  logic        b_in_ready;
  logic [25:0] b_x = '0;
  logic        b_out_valid;
  logic        b_out_ready = 1'b0;
  logic [3:0]  b_r1;
  logic [4:0]  b_r2;
  logic [8:0]  b_r3;
  logic [9:0]  b_r4;

  int errors = 0;
  int checks = 0;

  rns_forward_converter #(.N(NA), .P(PA)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .x_in(a_x),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .r1(a_r1), .r2(a_r2), .r3(a_r3), .r4(a_r4)
  );

  rns_forward_converter #(.N(NB), .P(PB)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .x_in(b_x),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .r1(b_r1), .r2(b_r2), .r3(b_r3), .r4(b_r4)
  );

  function automatic longint crt(input longint r1, input longint r2,
                                 input longint r3, input longint r4);
    longint a;
    a = -1;
    for (longint t = 0; t < 65535; t++) begin
      if (t % 15 == r1 && t % 17 == r2 && t % 257 == r3) begin
        a = t;
        break;
      end
    end
    if (a < 0) return -1;
    for (longint k = 0; k < 1024; k++) begin
      if ((a + 65535 * k) % 1024 == r4) return a + 65535 * k;
    end
    return -1;
  endfunction

  task automatic run_a(input logic [11:0] x, output int lat);
    @(negedge clk);
    a_x = x;
    a_in_valid = 1'b1;
    a_out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    a_in_valid = 1'b0;
    a_x = ~x;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (a_out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic finish_a();
    @(negedge clk);
    a_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_out_ready = 1'b0;
  endtask

  task automatic run_b(input logic [25:0] x, output int lat);
    @(negedge clk);
    b_x = x;
    b_in_valid = 1'b1;
    b_out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    b_in_valid = 1'b0;
    b_x = ~x;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (b_out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic finish_b();
    @(negedge clk);
    b_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic seen;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (a_in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_a_in_ready: got %b want 1", a_in_ready);
    end
    checks++;
    if (a_out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_a_out_valid: got %b want 0", a_out_valid);
    end
    checks++;
    if ({a_r1, a_r2, a_r3, a_r4} !== 14'd0) begin
      errors++; $display("FAIL rst_a_res: got %h want 0", {a_r1, a_r2, a_r3, a_r4});
    end
    checks++;
    if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_b_hs: got rdy=%b vld=%b want 1 0", b_in_ready, b_out_valid);
    end
    checks++;
    if ({b_r1, b_r2, b_r3, b_r4} !== 28'd0) begin
      errors++; $display("FAIL rst_b_res: got %h want 0", {b_r1, b_r2, b_r3, b_r4});
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
      errors++; $display("FAIL rel_a_hs: got rdy=%b vld=%b want 1 0", a_in_ready, a_out_valid);
    end
    // reset in the middle of ACCUM
    @(negedge clk);
    a_x = 12'd100;
    a_in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (a_in_ready !== 1'b0) begin
      errors++; $display("FAIL busy_in_ready: got %b want 0", a_in_ready);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
      errors++; $display("FAIL mid_rst_hs: got rdy=%b vld=%b want 1 0", a_in_ready, a_out_valid);
    end
    checks++;
    if (a_r4 !== 4'd0) begin
      errors++; $display("FAIL mid_rst_r4: got %0d want 0", a_r4);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (a_out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL mid_rst_no_out: got %b want 0", seen);
    end
  endtask

  task automatic test_conv_small();
    int lat;
    run_a(12'd100, lat);
    checks++;
    if (lat != 8) begin
      errors++; $display("FAIL a100_latency: got %0d want 8", lat);
    end
    checks++;
    if (a_in_ready !== 1'b0) begin
      errors++; $display("FAIL a100_in_ready: got %b want 0", a_in_ready);
    end
    checks++;
    if ({a_r1, a_r2, a_r3, a_r4} !== {2'd1, 3'd0, 5'd15, 4'd4}) begin
      errors++;
      $display("FAIL a100_res: got %0d %0d %0d %0d want 1 0 15 4", a_r1, a_r2, a_r3, a_r4);
    end
    finish_a();
    run_a(12'd4095, lat);
    checks++;
    if (lat != 8) begin
      errors++; $display("FAIL a4095_latency: got %0d want 8", lat);
    end
    checks++;
    if ({a_r1, a_r2, a_r3, a_r4} !== {2'd0, 3'd0, 5'd15, 4'd15}) begin
      errors++;
      $display("FAIL a4095_res: got %0d %0d %0d %0d want 0 0 15 15", a_r1, a_r2, a_r3, a_r4);
    end
    finish_a();
  endtask

  task automatic test_conv_wide();
    int lat;
    run_b(26'd0, lat);
    checks++;
    if (lat != 8 || {b_r1, b_r2, b_r3, b_r4} !== 28'd0) begin
      errors++;
      $display("FAIL b0_res: got lat=%0d %0d %0d %0d %0d want 8 0 0 0 0",
               lat, b_r1, b_r2, b_r3, b_r4);
    end
    finish_b();
    run_b(26'h3ffffff, lat);
    checks++;
    if ({b_r1, b_r2, b_r3, b_r4} !== {4'd3, 5'd3, 9'd252, 10'd1023}) begin
      errors++;
      $display("FAIL bmax_res: got %0d %0d %0d %0d want 3 3 252 1023", b_r1, b_r2, b_r3, b_r4);
    end
    finish_b();
    run_b(26'd1000, lat);
    checks++;
    if ({b_r1, b_r2, b_r3, b_r4} !== {4'd10, 5'd14, 9'd229, 10'd1000}) begin
      errors++;
      $display("FAIL b1000_res: got %0d %0d %0d %0d want 10 14 229 1000", b_r1, b_r2, b_r3, b_r4);
    end
    finish_b();
  endtask

  task automatic test_backpressure();
    int lat;
    logic seen;
    run_b(26'd12345, lat);
    checks++;
    if (lat != 8 || {b_r1, b_r2, b_r3, b_r4} !== {4'd0, 5'd3, 9'd9, 10'd57}) begin
      errors++;
      $display("FAIL bp_res: got lat=%0d %0d %0d %0d %0d want 8 0 3 9 57",
               lat, b_r1, b_r2, b_r3, b_r4);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      b_in_valid = (i % 2 == 0);
      b_x = 26'(i * 777 + 5);
      checks++;
      if (b_out_valid !== 1'b1 || b_in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_hs: got vld=%b rdy=%b want 1 0", b_out_valid, b_in_ready);
      end
      checks++;
      if ({b_r1, b_r2, b_r3, b_r4} !== {4'd0, 5'd3, 9'd9, 10'd57}) begin
        errors++;
        $display("FAIL bp_hold_res: got %0d %0d %0d %0d want 0 3 9 57", b_r1, b_r2, b_r3, b_r4);
      end
    end
    @(negedge clk);
    b_in_valid = 1'b0;
    b_out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got vld=%b rdy=%b want 0 1", b_out_valid, b_in_ready);
    end
    @(negedge clk);
    b_out_ready = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (b_out_valid || !b_in_ready) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL bp_ignored_pulses: got busy=%b want 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    longint q[$];
    longint e;
    longint rt;
    int sent;
    int got;
    logic fired_in;
    sent = 0;
    got = 0;
    fired_in = 1'b0;
    for (int cyc = 0; cyc < 3000 && got < 20; cyc++) begin
      @(negedge clk);
      if (fired_in) b_in_valid = 1'b0;
      if (!b_in_valid && sent < 20 && $urandom_range(0, 2) != 0) begin
        b_x = 26'($urandom);
        b_in_valid = 1'b1;
      end
      b_out_ready = 1'($urandom_range(0, 1));
      fired_in = b_in_valid && b_in_ready;
      if (fired_in) begin
        q.push_back(longint'(b_x));
        sent++;
      end
      if (b_out_valid && b_out_ready) begin
        got++;
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL b2b_spurious: got output want none");
        end else begin
          e = q.pop_front();
          if (b_r1 !== 4'(e % 15) || b_r2 !== 5'(e % 17) ||
              b_r3 !== 9'(e % 257) || b_r4 !== 10'(e % 1024)) begin
            errors++;
            $display("FAIL b2b_res x=%0d: got %0d %0d %0d %0d want %0d %0d %0d %0d",
                     e, b_r1, b_r2, b_r3, b_r4, e % 15, e % 17, e % 257, e % 1024);
          end
          if (e < MB) begin
            checks++;
            rt = crt(longint'(b_r1), longint'(b_r2), longint'(b_r3), longint'(b_r4));
            if (rt != e) begin
              errors++; $display("FAIL b2b_roundtrip: got %0d want %0d", rt, e);
            end
          end
        end
      end
    end
    @(negedge clk);
    b_in_valid = 1'b0;
    b_out_ready = 1'b0;
    checks++;
    if (got != 20) begin
      errors++; $display("FAIL b2b_count: got %0d want 20", got);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_conv_small();
    test_conv_wide();
    test_backpressure();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
